scalar_issue: RTL and testbench
===============================

# scalar_issue

Scalar issue stage: sits directly downstream of the scalar functional-unit status table (fust_s) and upstream of the ALU, scalar load/store (SLS) and branch units. Per FU it captures the busy row and its operand tags, waits for the producing FUs to write back, then presents the op with a valid/ready handshake. On acceptance it pulses a busy-clear back to fust_s. While a branch is unresolved it blocks SLS issue and squashes speculative ALU/SLS ops on flush.

## Interface
- No parameters; FU count fixed at 3 (index 0 = ALU, 1 = SLS, 2 = BR).
- CLK  in  1  clock
- nRST  in  1  synchronous, active-low reset
- busy  in  3  fust_s out_busy, one bit per FU
- t1, t2  in  [2:0][1:0]  fust_s out_t1/out_t2; tag 0 = operand ready, tag k = waiting on FU k-1
- op_alu, op_sls, op_br  in  fust_s_row_t  fust_s out_op_* rows
- wb_done  in  3  one-cycle completion pulse per FU
- fu_ready  in  3  FU can accept an op this cycle
- flush  in  1  branch mispredict flush
- resolved  in  1  branch resolved, no flush
- issue_valid  out  3  op presented to FU i
- issue_alu, issue_sls, issue_br  out  fust_s_row_t  registered op for each FU
- clr_busy  out  3  one-cycle pulse; fust_s clears busy[i] on the same edge
- br_pending  out  1  issued branch not yet resolved

## Operation
- Per-FU slot FSM: IDLE, WAIT, ISSUE.
- IDLE -> WAIT when busy[i]=1. The slot captures the row and both tags into local registers. A tag whose producer has wb_done high in the capture cycle is captured as 0.
- WAIT: each local tag k≠0 clears to 0 when wb_done[k-1]=1. Transition WAIT -> ISSUE when both tags are 0. For SLS there is an extra condition: br_pending=0 and no BR handshake in the same cycle.
- ISSUE: issue_valid[i] = (state==ISSUE) & !(flush & i≠BR), which is combinational on flush. A handshake occurs when issue_valid[i]=1 and fu_ready[i]=1. On a handshake the slot pulses clr_busy[i] for that cycle and returns to IDLE. Without a handshake it holds the row and valid.
- Tags keep updating in ISSUE; they are already 0 there.
- br_pending: set on a BR handshake. Cleared on resolved or flush. If a set and a clear occur in the same cycle, set wins (new branch).
- flush: ALU and SLS slots in WAIT or ISSUE go to IDLE next edge with no clr_busy (fust_s flushes itself). The BR slot is unaffected. A flush-cycle handshake on ALU/SLS cannot occur because valid is gated.
- flush + resolved together: flush takes precedence.
- Ops with both tags 0 at capture: WAIT is still entered for one cycle. Minimum capture-to-valid is 2 cycles.

## Timing
- Reset (nRST=0 at an edge): all slots IDLE, tags 0, rows 0, issue_valid=0, clr_busy=0, br_pending=0. Reset mid-handshake drops valid the next cycle.
- Latency: busy rise in cycle N -> WAIT at N+1 -> issue_valid at N+2 if operands are ready. A wb_done in cycle M clears the tag so that valid rises at M+2 at the earliest.
- After clr_busy in cycle H, busy[i] is low at H+1 and the slot is IDLE, so no double capture. A new busy at H+1 or later is captured normally.
- issue_* rows stay stable while issue_valid=1.

## Structure
- In datapath_pkg: fust_s_row_t (existing), fu_scalar_t, a tag typedef (2 bits), constants FU_ALU=0/FU_SLS=1/FU_BR=2, and the slot state enum.
- One sub-module, scalar_issue_slot, instantiated 3 times. It holds FSM, row, tags, wb wakeup and handshake, with an extra block input for the SLS branch gate.
- Top level holds only br_pending and the flush gating.
- New interface file scalar_issue_if.vh with modport ISSUE.

## Test plan
- Reset: hold nRST=0 with busy=3'b111 -> all outputs 0. Release -> valid 2 cycles after busy.
- Dependency wakeup: ALU t1=2 (SLS), t2=0. Pulse wb_done[1] at cycle 5 -> issue_valid[0] rises at cycle 7. With fu_ready[0]=1 -> clr_busy[0] pulses exactly 1 cycle.
- Backpressure: fu_ready[2]=0 for 4 cycles -> issue_valid[2] and issue_br held constant. When ready rises -> single handshake and br_pending=1.
- Branch gate: br_pending=1 with SLS tags 0 -> issue_valid[1] stays 0. Pulse resolved -> valid[1] rises 2 cycles later.
- Flush: ALU in ISSUE, SLS in WAIT, BR in ISSUE, flush=1 with all fu_ready=1 -> valid[0]=0 that cycle, ALU/SLS IDLE next, no clr_busy[0/1]. BR handshake completes and br_pending ends 1.
- Capture bypass: busy[0] rises with t1=1 while wb_done[0]=1 the same cycle -> the captured tag is 0 and valid rises 2 cycles later.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared scalar datapath types: fust_s row layout, FU indices, operand tags
// and the issue-slot state encoding.
package datapath_pkg;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fust_s_row_t;

  typedef logic [1:0] tag_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_SLS = 2'd1,
    FU_BR  = 2'd2
  } fu_scalar_t;

  localparam int NUM_FU = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_WAIT,
    SLOT_ISSUE
  } slot_state_t;

  // Tag k names producer FU k-1; its writeback pulse turns the tag into "ready".
  function automatic tag_t wake_tag(input tag_t tag, input logic [2:0] wb);
    logic hit;
    unique case (tag)
      2'd1:    hit = wb[0];
      2'd2:    hit = wb[1];
      2'd3:    hit = wb[2];
      default: hit = 1'b0;
    endcase
    return hit ? 2'd0 : tag;
  endfunction

endpackage

// File: rtl/scalar_issue_if.sv
// Bundle of the issue-side signals towards the scalar FUs.
interface scalar_issue_if import datapath_pkg::*; ();
  logic [2:0]  issue_valid;
  fust_s_row_t issue_alu;
  fust_s_row_t issue_sls;
  fust_s_row_t issue_br;
  logic [2:0]  clr_busy;
  logic [2:0]  fu_ready;

  modport ISSUE (
    output issue_valid, issue_alu, issue_sls, issue_br, clr_busy,
    input  fu_ready
  );
endinterface

// File: rtl/scalar_issue_slot.sv
// One per-FU issue slot: captures a busy row, waits for operand writeback,
// then holds the op valid until the FU accepts it.
module scalar_issue_slot import datapath_pkg::*; (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        busy_i,
  input  tag_t        t1_i,
  input  tag_t        t2_i,
  input  fust_s_row_t row_i,
  input  logic [2:0]  wb_done_i,
  input  logic        fu_ready_i,
  input  logic        kill_i,
  input  logic        gate_i,
  output logic        issue_valid_o,
  output fust_s_row_t row_o,
  output logic        clr_busy_o
);

  slot_state_t state_q;
  tag_t        t1_q, t2_q, t1_d, t2_d;
  fust_s_row_t row_q;
  logic        capture;
  logic        handshake;

  // A kill in IDLE skips capture: fust_s is dropping that row on the same flush.
  assign capture       = (state_q == SLOT_IDLE) && busy_i && !kill_i;
  assign issue_valid_o = (state_q == SLOT_ISSUE) && !kill_i;
  assign handshake     = issue_valid_o && fu_ready_i;
  assign clr_busy_o    = handshake;
  assign row_o         = row_q;

  always_comb begin
    t1_d = wake_tag(t1_q, wb_done_i);
    t2_d = wake_tag(t2_q, wb_done_i);
    if (capture) begin
      t1_d = wake_tag(t1_i, wb_done_i);
      t2_d = wake_tag(t2_i, wb_done_i);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= SLOT_IDLE;
      t1_q    <= '0;
      t2_q    <= '0;
      row_q   <= '0;
    end else begin
      t1_q <= t1_d;
      t2_q <= t2_d;
      unique case (state_q)
        SLOT_IDLE: begin
          if (capture) begin
            row_q   <= row_i;
            state_q <= SLOT_WAIT;
          end
        end
        SLOT_WAIT: begin
          if (kill_i) begin
            state_q <= SLOT_IDLE;
          end else if (t1_q == 2'd0 && t2_q == 2'd0 && gate_i) begin
            state_q <= SLOT_ISSUE;
          end
        end
        SLOT_ISSUE: begin
          if (kill_i || handshake) begin
            state_q <= SLOT_IDLE;
          end
        end
        default: state_q <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scalar_issue.sv
// Scalar issue stage: three issue slots plus branch-pending tracking that
// blocks SLS issue and flush gating of the speculative ALU/SLS slots.
module scalar_issue import datapath_pkg::*; (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [2:0]      busy,
  input  logic [2:0][1:0] t1,
  input  logic [2:0][1:0] t2,
  input  fust_s_row_t     op_alu,
  input  fust_s_row_t     op_sls,
  input  fust_s_row_t     op_br,
  input  logic [2:0]      wb_done,
  input  logic [2:0]      fu_ready,
  input  logic            flush,
  input  logic            resolved,
  output logic [2:0]      issue_valid,
  output fust_s_row_t     issue_alu,
  output fust_s_row_t     issue_sls,
  output fust_s_row_t     issue_br,
  output logic [2:0]      clr_busy,
  output logic            br_pending
);

  logic br_pending_q, br_pending_d;
  logic validAlu, validSls, validBr;
  logic clrAlu, clrSls, clrBr;
  logic slsGate;

  // SLS may not leave WAIT behind an unresolved branch, including one issuing now.
  assign slsGate     = !br_pending_q && !clrBr;
  assign issue_valid = {validBr, validSls, validAlu};
  assign clr_busy    = {clrBr, clrSls, clrAlu};
  assign br_pending  = br_pending_q;

  always_comb begin
    br_pending_d = br_pending_q;
    if (clrBr) begin
      br_pending_d = 1'b1;
    end else if (flush || resolved) begin
      br_pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      br_pending_q <= 1'b0;
    end else begin
      br_pending_q <= br_pending_d;
    end
  end

  scalar_issue_slot u_slot_alu (
    .CLK(CLK), .nRST(nRST), .busy_i(busy[0]), .t1_i(t1[0]), .t2_i(t2[0]),
    .row_i(op_alu), .wb_done_i(wb_done), .fu_ready_i(fu_ready[0]),
    .kill_i(flush), .gate_i(1'b1),
    .issue_valid_o(validAlu), .row_o(issue_alu), .clr_busy_o(clrAlu)
  );

  scalar_issue_slot u_slot_sls (
    .CLK(CLK), .nRST(nRST), .busy_i(busy[1]), .t1_i(t1[1]), .t2_i(t2[1]),
    .row_i(op_sls), .wb_done_i(wb_done), .fu_ready_i(fu_ready[1]),
    .kill_i(flush), .gate_i(slsGate),
    .issue_valid_o(validSls), .row_o(issue_sls), .clr_busy_o(clrSls)
  );

  scalar_issue_slot u_slot_br (
    .CLK(CLK), .nRST(nRST), .busy_i(busy[2]), .t1_i(t1[2]), .t2_i(t2[2]),
    .row_i(op_br), .wb_done_i(wb_done), .fu_ready_i(fu_ready[2]),
    .kill_i(1'b0), .gate_i(1'b1),
    .issue_valid_o(validBr), .row_o(issue_br), .clr_busy_o(clrBr)
  );

endmodule

// File: tb/tb_scalar_issue.sv
// Directed bench for scalar_issue: reset, wakeup latency, backpressure,
// branch gating of SLS, flush squash and capture-cycle writeback bypass.
module tb_scalar_issue;
  import datapath_pkg::*;

  logic            CLK;
  logic            nRST;
  logic [2:0]      busy;
  logic [2:0][1:0] t1, t2;
  fust_s_row_t     op_alu, op_sls, op_br;
  logic [2:0]      wb_done, fu_ready;
  logic            flush, resolved;
  logic [2:0]      issue_valid;
  fust_s_row_t     issue_alu, issue_sls, issue_br;
  logic [2:0]      clr_busy;
  logic            br_pending;

  int totalChecks = 0;
  int badChecks = 0;

  fust_s_row_t rowA, rowS, rowB, rowA2, rowB2, rowS2, rowA3, rowS3, rowB3;

  scalar_issue dut (
    .CLK(CLK), .nRST(nRST), .busy(busy), .t1(t1), .t2(t2),
    .op_alu(op_alu), .op_sls(op_sls), .op_br(op_br),
    .wb_done(wb_done), .fu_ready(fu_ready), .flush(flush), .resolved(resolved),
    .issue_valid(issue_valid), .issue_alu(issue_alu), .issue_sls(issue_sls),
    .issue_br(issue_br), .clr_busy(clr_busy), .br_pending(br_pending)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs change 1ns after the rising edge; checks happen well before the next one.
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rowA  = '{opcode: 7'h13, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  imm: 32'h0000_1111};
    rowS  = '{opcode: 7'h03, rd: 5'd4,  rs1: 5'd5,  rs2: 5'd6,  imm: 32'h0000_2222};
    rowB  = '{opcode: 7'h63, rd: 5'd0,  rs1: 5'd7,  rs2: 5'd8,  imm: 32'h0000_3333};
    rowA2 = '{opcode: 7'h33, rd: 5'd9,  rs1: 5'd10, rs2: 5'd11, imm: 32'hA5A5_0001};
    rowB2 = '{opcode: 7'h67, rd: 5'd12, rs1: 5'd13, rs2: 5'd14, imm: 32'hB2B2_0002};
    rowS2 = '{opcode: 7'h23, rd: 5'd15, rs1: 5'd16, rs2: 5'd17, imm: 32'h5252_0003};
    rowA3 = '{opcode: 7'h13, rd: 5'd18, rs1: 5'd19, rs2: 5'd20, imm: 32'hCAFE_0004};
    rowS3 = '{opcode: 7'h03, rd: 5'd21, rs1: 5'd22, rs2: 5'd23, imm: 32'hBEEF_0005};
    rowB3 = '{opcode: 7'h63, rd: 5'd24, rs1: 5'd25, rs2: 5'd26, imm: 32'hF00D_0006};

    nRST = 1'b0; busy = 3'b111; t1 = '0; t2 = '0;
    op_alu = rowA; op_sls = rowS; op_br = rowB;
    wb_done = 3'b000; fu_ready = 3'b111; flush = 1'b0; resolved = 1'b0;

    // Reset held with busy and ready asserted: nothing issues.
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid", 64'(issue_valid), 64'(3'b000));
    checkOutput("rst_clr", 64'(clr_busy), 64'(3'b000));
    checkOutput("rst_brp", 64'(br_pending), 64'(1'b0));
    checkOutput("rst_row_alu", 64'(issue_alu), 64'(0));

    // Release: capture edge, WAIT, then valid two cycles after busy.
    nRST = 1'b1; fu_ready = 3'b000;
    applyStimulus();
    busy = 3'b000; #1;
    checkOutput("lat_wait_valid", 64'(issue_valid), 64'(3'b000));
    applyStimulus();
    checkOutput("lat_issue_valid", 64'(issue_valid), 64'(3'b111));
    checkOutput("lat_row_alu", 64'(issue_alu), 64'(rowA));
    checkOutput("lat_row_sls", 64'(issue_sls), 64'(rowS));
    checkOutput("lat_row_br", 64'(issue_br), 64'(rowB));
    fu_ready = 3'b111; #1;
    checkOutput("lat_clr", 64'(clr_busy), 64'(3'b111));
    applyStimulus();
    fu_ready = 3'b000; #1;
    checkOutput("lat_post_valid", 64'(issue_valid), 64'(3'b000));
    checkOutput("lat_post_clr", 64'(clr_busy), 64'(3'b000));
    checkOutput("lat_brp_set", 64'(br_pending), 64'(1'b1));
    resolved = 1'b1;
    applyStimulus();
    resolved = 1'b0; #1;
    checkOutput("resolve_brp", 64'(br_pending), 64'(1'b0));

    // Dependency wakeup: ALU waits on SLS (tag 2) until wb_done[1].
    busy = 3'b001; t1 = 6'b00_00_10; op_alu = rowA2;
    applyStimulus();
    busy = 3'b000; t1 = '0; op_alu = rowA;
    applyStimulus();
    applyStimulus();
    checkOutput("dep_waiting", 64'(issue_valid), 64'(3'b000));
    wb_done = 3'b010;
    applyStimulus();
    wb_done = 3'b000; #1;
    checkOutput("dep_wb_plus1", 64'(issue_valid), 64'(3'b000));
    applyStimulus();
    checkOutput("dep_wb_plus2", 64'(issue_valid), 64'(3'b001));
    checkOutput("dep_row", 64'(issue_alu), 64'(rowA2));
    fu_ready = 3'b001; #1;
    checkOutput("dep_clr", 64'(clr_busy), 64'(3'b001));
    applyStimulus();
    fu_ready = 3'b000; #1;
    checkOutput("dep_clr_once", 64'(clr_busy), 64'(3'b000));
    checkOutput("dep_idle", 64'(issue_valid), 64'(3'b000));

    // Backpressure on BR: row and valid hold while the input row changes.
    busy = 3'b100; op_br = rowB2;
    applyStimulus();
    busy = 3'b000; op_br = rowB;
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_valid", 64'(issue_valid), 64'(3'b100));
      checkOutput("bp_row", 64'(issue_br), 64'(rowB2));
      checkOutput("bp_clr", 64'(clr_busy), 64'(3'b000));
      applyStimulus();
    end
    fu_ready = 3'b100; #1;
    checkOutput("bp_hs_clr", 64'(clr_busy), 64'(3'b100));
    checkOutput("bp_brp_before", 64'(br_pending), 64'(1'b0));
    applyStimulus();
    fu_ready = 3'b000; #1;
    checkOutput("bp_brp_after", 64'(br_pending), 64'(1'b1));
    checkOutput("bp_idle", 64'(issue_valid), 64'(3'b000));

    // Branch gate: ready SLS op held back until the branch resolves.
    busy = 3'b010; op_sls = rowS2;
    applyStimulus();
    busy = 3'b000; op_sls = rowS;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("gate_hold", 64'(issue_valid), 64'(3'b000));
    end
    resolved = 1'b1;
    applyStimulus();
    resolved = 1'b0; #1;
    checkOutput("gate_brp_clr", 64'(br_pending), 64'(1'b0));
    checkOutput("gate_plus1", 64'(issue_valid), 64'(3'b000));
    applyStimulus();
    checkOutput("gate_plus2", 64'(issue_valid), 64'(3'b010));
    checkOutput("gate_row", 64'(issue_sls), 64'(rowS2));
    fu_ready = 3'b010; #1;
    checkOutput("gate_clr", 64'(clr_busy), 64'(3'b010));
    applyStimulus();
    fu_ready = 3'b000;

    // Flush: ALU and BR in ISSUE, SLS in WAIT on the ALU result.
    busy = 3'b111; t1 = 6'b00_01_00; op_alu = rowA3; op_sls = rowS3; op_br = rowB3;
    applyStimulus();
    busy = 3'b000; t1 = '0;
    applyStimulus();
    checkOutput("fl_pre_valid", 64'(issue_valid), 64'(3'b101));
    flush = 1'b1; fu_ready = 3'b111; #1;
    checkOutput("fl_valid_gated", 64'(issue_valid), 64'(3'b100));
    checkOutput("fl_clr", 64'(clr_busy), 64'(3'b100));
    applyStimulus();
    flush = 1'b0; fu_ready = 3'b000; #1;
    checkOutput("fl_post_valid", 64'(issue_valid), 64'(3'b000));
    checkOutput("fl_post_clr", 64'(clr_busy), 64'(3'b000));
    checkOutput("fl_brp", 64'(br_pending), 64'(1'b1));
    wb_done = 3'b001; resolved = 1'b1;
    applyStimulus();
    wb_done = 3'b000; resolved = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("fl_sls_dead", 64'(issue_valid), 64'(3'b000));
    checkOutput("fl_brp_clr", 64'(br_pending), 64'(1'b0));

    // Capture bypass: producer writes back in the capture cycle.
    busy = 3'b001; t1 = 6'b00_00_01; wb_done = 3'b001; op_alu = rowA;
    applyStimulus();
    busy = 3'b000; t1 = '0; wb_done = 3'b000; #1;
    checkOutput("byp_wait", 64'(issue_valid), 64'(3'b000));
    applyStimulus();
    checkOutput("byp_valid", 64'(issue_valid), 64'(3'b001));
    checkOutput("byp_row", 64'(issue_alu), 64'(rowA));

    // Reset in the middle of a handshake drops valid the next cycle.
    fu_ready = 3'b001; nRST = 1'b0; #1;
    checkOutput("rstmid_clr", 64'(clr_busy), 64'(3'b001));
    applyStimulus();
    nRST = 1'b1; fu_ready = 3'b000; #1;
    checkOutput("rstmid_valid", 64'(issue_valid), 64'(3'b000));
    checkOutput("rstmid_row", 64'(issue_alu), 64'(0));
    checkOutput("rstmid_clr_off", 64'(clr_busy), 64'(3'b000));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
